// File: rtl/wptr_full_ctrl_pkg.sv
// Shared FIFO helpers: pointer-width derivation, Gray/binary conversion and
// the write-side status flag bundle. The read side imports the same package.
package wptr_full_ctrl_pkg;

  // Widest pointer the conversion helpers handle; callers zero-extend into it.
  localparam int unsigned GRAY_MAX_W = 32;

  // Pointers carry one bit more than the address to tell full from empty.
  function automatic int unsigned ptr_width(input int unsigned addr_size);
    return addr_size + 1;
  endfunction

  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
    return (b >> 1) ^ b;
  endfunction

  // Zero-extended input gives zero upper result bits, so truncation is safe.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Registered single-bit status flags of the write side.
  typedef struct packed {
    logic full;
    logic afull;
    logic ovf;
  } wflags_t;

endpackage

// File: rtl/sync_r2w.sv
// Two-flop synchronizer for a Gray pointer crossing into the local clock.
// Reused unchanged as the write-to-read synchronizer on the other side.
module sync_r2w #(
  parameter int unsigned WIDTH = 13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] q1_reg;
  logic [WIDTH-1:0] q2_reg;

  // Two back-to-back stages; only q2 is ever consumed downstream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q1_reg <= '0;
      q2_reg <= '0;
    end else begin
      q1_reg <= din;
      q2_reg <= q1_reg;
    end
  end

  assign dout = q2_reg;

endmodule

// File: rtl/wptr_full_ctrl.sv
// Write-side pointer and full/almost-full/level/overflow controller of the
// dual-clock FIFO. Status is computed from the synchronized (stale) read
// pointer, so it can only overstate occupancy, never understate it.
module wptr_full_ctrl
  import wptr_full_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_SIZE    = 12,
  parameter int unsigned AFULL_THRESH = (1 << ADDR_SIZE) - 4
) (
  input  logic                          wclk,
  input  logic                          wrst,
  input  logic                          winc,
  input  logic                          wovf_clr,
  input  logic [ptr_width(ADDR_SIZE)-1:0] wrptr,
  output logic                          wen,
  output logic [ADDR_SIZE-1:0]          waddr,
  output logic [ptr_width(ADDR_SIZE)-1:0] wptr,
  output logic                          wfull,
  output logic                          wafull,
  output logic [ptr_width(ADDR_SIZE)-1:0] wlevel,
  output logic                          wovf
);

  localparam int unsigned PTR_W = ptr_width(ADDR_SIZE);
  localparam int unsigned A     = ADDR_SIZE;
  localparam logic [PTR_W-1:0] AFULL_CMP = PTR_W'(AFULL_THRESH);

  logic [PTR_W-1:0] wq2;
  logic [PTR_W-1:0] rq2bin;
  logic [PTR_W-1:0] wbin_reg;
  logic [PTR_W-1:0] wptr_reg;
  logic [PTR_W-1:0] wlevel_reg;
  logic [PTR_W-1:0] wbin_next;
  logic [PTR_W-1:0] wgray_next;
  logic [PTR_W-1:0] level_next;
  logic [PTR_W-1:0] full_pattern;
  wflags_t          flags_reg;
  wflags_t          flags_next;

  sync_r2w #(
    .WIDTH (PTR_W)
  ) u_sync_r2w (
    .clk  (wclk),
    .rst  (wrst),
    .din  (wrptr),
    .dout (wq2)
  );

  // A write is accepted only when the registered full flag is clear.
  assign wen = winc & ~flags_reg.full;

  // Next pointer values and the occupancy they imply against the synced read pointer.
  always_comb begin
    wbin_next    = wbin_reg + PTR_W'(wen);
    wgray_next   = PTR_W'(bin2gray(GRAY_MAX_W'(wbin_next)));
    rq2bin       = PTR_W'(gray2bin(GRAY_MAX_W'(wq2)));
    level_next   = wbin_next - rq2bin;
    // Full when the Gray write pointer is exactly one lap ahead of the read pointer.
    full_pattern = {~wq2[A:A-1], wq2[A-2:0]};
    flags_next.full  = (wgray_next == full_pattern);
    flags_next.afull = (level_next >= AFULL_CMP);
    // Set wins over clear so a simultaneous clear never hides a fresh overflow.
    flags_next.ovf   = (winc & flags_reg.full) | (flags_reg.ovf & ~wovf_clr);
  end

  // Binary address counter and Gray pointer exported to the read side.
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      wbin_reg <= '0;
      wptr_reg <= '0;
    end else begin
      wbin_reg <= wbin_next;
      wptr_reg <= wgray_next;
    end
  end

  // Registered status: level, full, almost-full and sticky overflow.
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      wlevel_reg <= '0;
      flags_reg  <= '0;
    end else begin
      wlevel_reg <= level_next;
      flags_reg  <= flags_next;
    end
  end

  assign waddr  = wbin_reg[A-1:0];
  assign wptr   = wptr_reg;
  assign wlevel = wlevel_reg;
  assign wfull  = flags_reg.full;
  assign wafull = flags_reg.afull;
  assign wovf   = flags_reg.ovf;

endmodule
